// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU accumulator controller: FSM states,
// the passthrough key code and the default undo history depth.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLE   = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  // Active-low key code that makes the ALU pass the register straight through
  localparam logic [2:0] OP_PASS = 3'b000;

  localparam int HIST_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for an active-low push button plus a one-cycle
// pulse on its press (falling) edge; everything resets to "released".
module button_sync (
  input  logic clock,
  input  logic resetn,
  input  logic btn_n,
  output logic held,
  output logic press
);

  logic sync1;
  logic sync2;
  logic last;

  // The third flop remembers the previous synchronized level for edge detection
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      last  <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      last  <= sync2;
    end
  end

  assign held  = ~sync2;
  assign press = last & ~sync2;

endmodule

// File: rtl/alu_accumulator_ctrl.sv
// Sequencer for the lab ALU: latches the requested function on a load press,
// captures the ALU result into the register and keeps an undo history.
module alu_accumulator_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int HIST_DEPTH = HIST_DEPTH_DEFAULT,
  parameter int DATA_W     = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [2:0]        func_n,
  input  logic              load_n,
  input  logic              undo_n,
  input  logic [DATA_W-1:0] alu_out,
  output logic [2:0]        key_out,
  output logic [DATA_W-1:0] register,
  output logic              busy,
  output logic [2:0]        hist_count
);

  localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [2:0] FULL = 3'(HIST_DEPTH);

  state_t state;
  state_t next_state;

  logic load_held;
  logic load_press;
  logic undo_held;
  logic undo_press;

  logic latch_key;
  logic push;
  logic pop;

  logic [DATA_W-1:0] mem [HIST_DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     wp_prev;
  logic [2:0]        count;

  button_sync u_load_sync (
    .clock  (clock),
    .resetn (resetn),
    .btn_n  (load_n),
    .held   (load_held),
    .press  (load_press)
  );

  button_sync u_undo_sync (
    .clock  (clock),
    .resetn (resetn),
    .btn_n  (undo_n),
    .held   (undo_held),
    .press  (undo_press)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Undo is only honoured in IDLE and only when no load arrives the same cycle
  always_comb begin
    next_state = state;
    latch_key  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_press) begin
          latch_key  = 1'b1;
          next_state = S_SETTLE;
        end else if (undo_press && undo_held && (count != 3'd0)) begin
          pop = 1'b1;
        end
      end
      S_SETTLE: begin
        push       = 1'b1;
        next_state = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!load_held) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign wp_prev = wp - PW'(1);

  // When full, wp points at the oldest entry, so a push overwrites it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_out  <= OP_PASS;
      register <= '0;
      wp       <= '0;
      count    <= 3'd0;
    end else begin
      if (latch_key) key_out <= func_n;
      if (push) begin
        register <= alu_out;
        wp       <= wp + PW'(1);
        if (count != FULL) count <= count + 3'd1;
      end else if (pop) begin
        register <= mem[wp_prev];
        wp       <= wp_prev;
        count    <= count - 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= register;
  end

  assign busy       = (state != S_IDLE);
  assign hist_count = count;

endmodule

// File: tb/tb_alu_accumulator_ctrl.sv
// Directed bench for alu_accumulator_ctrl with a small A+B ALU model
// closing the loop from key_out/register back to alu_out.
module tb_alu_accumulator_ctrl;

  logic       clock;
  logic       resetn;
  logic [2:0] func_n;
  logic       load_n;
  logic       undo_n;
  logic [7:0] alu_out;
  logic [2:0] key_out;
  logic [7:0] register;
  logic       busy;
  logic [2:0] hist_count;

  logic [3:0] a_val;
  logic [2:0] op;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic       doLoad;
    logic       doUndo;
    logic [3:0] a;
    logic [7:0] expReg;
    logic [2:0] expCnt;
  } vec_t;

  vec_t vecs [16];

  alu_accumulator_ctrl dut (
    .clock      (clock),
    .resetn     (resetn),
    .func_n     (func_n),
    .load_n     (load_n),
    .undo_n     (undo_n),
    .alu_out    (alu_out),
    .key_out    (key_out),
    .register   (register),
    .busy       (busy),
    .hist_count (hist_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU model: op 1 adds A to the register, everything else passes it through
  always_comb begin
    op      = ~key_out;
    alu_out = (op == 3'd1) ? (register + {4'b0000, a_val}) : register;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic doLoad, input logic doUndo);
    @(negedge clock);
    load_n = ~doLoad;
    undo_n = ~doUndo;
    repeat (3) @(negedge clock);
    load_n = 1'b1;
    undo_n = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    resetn = 1'b0;
    func_n = 3'b111;
    load_n = 1'b1;
    undo_n = 1'b1;
    a_val  = 4'h3;

    vecs[0]  = '{1'b1, 1'b0, 4'h3, 8'h06, 3'd2};
    vecs[1]  = '{1'b0, 1'b1, 4'h3, 8'h03, 3'd1};
    vecs[2]  = '{1'b0, 1'b1, 4'h3, 8'h00, 3'd0};
    vecs[3]  = '{1'b0, 1'b1, 4'h3, 8'h00, 3'd0};
    vecs[4]  = '{1'b1, 1'b0, 4'h1, 8'h01, 3'd1};
    vecs[5]  = '{1'b1, 1'b0, 4'h1, 8'h02, 3'd2};
    vecs[6]  = '{1'b1, 1'b0, 4'h1, 8'h03, 3'd3};
    vecs[7]  = '{1'b1, 1'b0, 4'h1, 8'h04, 3'd4};
    vecs[8]  = '{1'b1, 1'b0, 4'h1, 8'h05, 3'd4};
    vecs[9]  = '{1'b0, 1'b1, 4'h1, 8'h04, 3'd3};
    vecs[10] = '{1'b0, 1'b1, 4'h1, 8'h03, 3'd2};
    vecs[11] = '{1'b0, 1'b1, 4'h1, 8'h02, 3'd1};
    vecs[12] = '{1'b0, 1'b1, 4'h1, 8'h01, 3'd0};
    vecs[13] = '{1'b0, 1'b1, 4'h1, 8'h01, 3'd0};
    vecs[14] = '{1'b1, 1'b0, 4'h1, 8'h02, 3'd1};
    vecs[15] = '{1'b1, 1'b1, 4'h1, 8'h03, 3'd2};

    repeat (3) @(negedge clock);
    checkOutput("reset register", register, 8'h00);
    checkOutput("reset key_out", {5'b0, key_out}, 8'h00);
    checkOutput("reset busy", {7'b0, busy}, 8'h00);
    checkOutput("reset hist_count", {5'b0, hist_count}, 8'h00);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // First load with per-edge latency checks
    func_n = 3'b110;
    load_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("edge2 key_out", {5'b0, key_out}, 8'h00);
    checkOutput("edge2 busy", {7'b0, busy}, 8'h00);
    @(negedge clock);
    checkOutput("edge3 key_out", {5'b0, key_out}, 8'h06);
    checkOutput("edge3 busy", {7'b0, busy}, 8'h01);
    checkOutput("edge3 register", register, 8'h00);
    @(negedge clock);
    checkOutput("edge4 register", register, 8'h03);
    checkOutput("edge4 hist_count", {5'b0, hist_count}, 8'h01);
    load_n = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("after load busy", {7'b0, busy}, 8'h00);

    for (int i = 0; i < 16; i++) begin
      a_val = vecs[i].a;
      applyStimulus(vecs[i].doLoad, vecs[i].doUndo);
      checkOutput($sformatf("vec%0d register", i), register, vecs[i].expReg);
      checkOutput($sformatf("vec%0d hist_count", i), {5'b0, hist_count}, {5'b0, vecs[i].expCnt});
      checkOutput($sformatf("vec%0d key_out", i), {5'b0, key_out}, 8'h06);
      checkOutput($sformatf("vec%0d busy", i), {7'b0, busy}, 8'h00);
    end

    // Held load: exactly one capture, busy until the release is synchronized
    @(negedge clock);
    load_n = 1'b0;
    repeat (20) @(negedge clock);
    checkOutput("hold register", register, 8'h04);
    checkOutput("hold hist_count", {5'b0, hist_count}, 8'h03);
    checkOutput("hold busy", {7'b0, busy}, 8'h01);
    load_n = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("release busy early", {7'b0, busy}, 8'h01);
    @(negedge clock);
    checkOutput("release busy done", {7'b0, busy}, 8'h00);
    repeat (3) @(negedge clock);
    checkOutput("release register", register, 8'h04);

    // Reset asserted while in SETTLE
    load_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("pre-reset busy", {7'b0, busy}, 8'h01);
    resetn = 1'b0;
    #1;
    checkOutput("midreset register", register, 8'h00);
    checkOutput("midreset key_out", {5'b0, key_out}, 8'h00);
    checkOutput("midreset busy", {7'b0, busy}, 8'h00);
    checkOutput("midreset hist_count", {5'b0, hist_count}, 8'h00);
    load_n = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("post-reset register", register, 8'h00);
    checkOutput("post-reset hist_count", {5'b0, hist_count}, 8'h00);
    checkOutput("post-reset busy", {7'b0, busy}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
